seq_multiplier: RTL and testbench

Parametrised multi-cycle integer multiplier, the sequential successor to the combinational multiplier_N family. It trades area for latency by retiring BITS_PER_CYCLE multiplier bits per clock (shift-add on magnitudes). It supports signed and unsigned operands and uses valid/ready handshakes on both input and output, so it drops directly into pipelined datapaths with backpressure.

---
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock on
// operand magnitudes and applies the sign at the end; valid/ready on input and output.
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // BUSY  | N shift-add steps in progress
    // DONE  | product valid, held until out_ready
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [2*WIDTH-1:0] mcand_sh, acc, acc_nx;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               neg, accept, last;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign mag_a  = (is_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b  = (is_signed && B[WIDTH-1]) ? -B : B;
    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == CW'(N - 1));

    always_comb begin
        acc_nx = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                acc_nx = acc_nx + (mcand_sh << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_sh <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            product  <= '0;
        end else if (accept) begin
            mcand_sh <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            acc      <= '0;
            cnt      <= '0;
            neg      <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
        end else if (state == BUSY) begin
            acc      <= acc_nx;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mplier   <= mplier >> BITS_PER_CYCLE;
            cnt      <= cnt + CW'(1);
            if (last) begin
                product <= neg ? -acc_nx : acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a 32-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance,
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_seq_multiplier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv0, ir0, s0, ov0, or0, bz0;
    logic [31:0] a0, b0;
    logic [63:0] p0;
    logic        iv1, ir1, s1, ov1, or1, bz1;
    logic [15:0] a1, b1;
    logic [31:0] p1;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .is_signed(s0), .out_valid(ov0), .out_ready(or0), .product(p0), .busy(bz0)
    );

    seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .is_signed(s1), .out_valid(ov1), .out_ready(or1), .product(p1), .busy(bz1)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit armed = 1'b0;

    typedef struct {
        logic [63:0] p;
        int          t;
    } job_t;
    job_t q0[$];
    job_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Exact product from plain integer arithmetic, zero-padded to 64 bits.
    function automatic logic [63:0] model(int id, logic [31:0] a, logic [31:0] b, logic s);
        longint           sa, sb;
        logic signed [15:0] ha, hb;
        int               ia, ib;
        logic [31:0]      r;
        if (id == 0) begin
            if (s) begin
                sa = longint'(signed'(a));
                sb = longint'(signed'(b));
                return 64'(sa * sb);
            end
            return 64'(a) * 64'(b);
        end
        ha = a[15:0];
        hb = b[15:0];
        if (s) begin
            ia = int'(ha);
            ib = int'(hb);
            r  = 32'(ia * ib);
        end else begin
            r = 32'(a[15:0]) * 32'(b[15:0]);
        end
        return {32'b0, r};
    endfunction

    function automatic logic get_ov(int id);
        return (id == 0) ? ov0 : ov1;
    endfunction
    function automatic logic get_ir(int id);
        return (id == 0) ? ir0 : ir1;
    endfunction
    function automatic logic get_bz(int id);
        return (id == 0) ? bz0 : bz1;
    endfunction
    function automatic logic get_or(int id);
        return (id == 0) ? or0 : or1;
    endfunction
    function automatic logic [63:0] get_p(int id);
        return (id == 0) ? p0 : {32'b0, p1};
    endfunction

    task automatic set_in(int id, logic [31:0] a, logic [31:0] b, logic s, logic v);
        if (id == 0) begin
            a0 = a; b0 = b; s0 = s; iv0 = v;
        end else begin
            a1 = a[15:0]; b1 = b[15:0]; s1 = s; iv1 = v;
        end
    endtask

    task automatic set_or(int id, logic v);
        if (id == 0) or0 = v;
        else         or1 = v;
    endtask

    // A job's result must be visible exactly N+1 negedges after the negedge preceding its accept edge.
    task automatic check_one(int id);
        logic        iv, ov, orr, s, exp_ov;
        logic [31:0] a, b;
        int          n, qs;
        job_t        f;
        if (id == 0) begin
            iv = iv0; a = a0; b = b0; s = s0; n = 32; qs = q0.size();
            if (qs != 0) f = q0[0];
        end else begin
            iv = iv1; a = {16'b0, a1}; b = {16'b0, b1}; s = s1; n = 4; qs = q1.size();
            if (qs != 0) f = q1[0];
        end
        ov  = get_ov(id);
        orr = get_or(id);
        chk1($sformatf("in_ready[%0d]", id), get_ir(id), qs == 0);
        chk1($sformatf("busy[%0d]", id), get_bz(id), qs != 0);
        exp_ov = (qs != 0) && (cyc - f.t >= n + 1);
        chk1($sformatf("out_valid[%0d]", id), ov, exp_ov);
        if (exp_ov) chk($sformatf("product[%0d]", id), get_p(id), f.p);
        if (!rst_n) begin
            if (id == 0) q0.delete();
            else         q1.delete();
        end else begin
            if (exp_ov && orr) begin
                if (id == 0) void'(q0.pop_front());
                else         void'(q1.pop_front());
            end
            if (iv && qs == 0) begin
                if (id == 0) q0.push_back('{model(id, a, b, s), cyc});
                else         q1.push_back('{model(id, a, b, s), cyc});
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check_one(0);
            check_one(1);
        end
    end

    task automatic accept(int id, logic [31:0] a, logic [31:0] b, logic s);
        @(posedge clk); #1;
        set_in(id, a, b, s, 1'b1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (get_ir(id)) break;
        end
        chk1("accept_ready", get_ir(id), 1'b1);
        @(posedge clk); #1;
        set_in(id, a, b, s, 1'b0);
    endtask

    task automatic wait_ov(int id, int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (get_ov(id)) break;
        end
        chk1("wait_out_valid", get_ov(id), 1'b1);
    endtask

    task automatic handoff(int id);
        @(posedge clk); #1;
        set_or(id, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        set_or(id, 1'b0);
    endtask

    task automatic run(int id, logic [31:0] a, logic [31:0] b, logic s, logic [63:0] exp, int hold);
        accept(id, a, b, s);
        set_or(id, hold == 0);
        wait_ov(id, 60);
        chk("directed_product", get_p(id), exp);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            set_or(id, 1'b1);
            @(negedge clk);
            chk("held_product", get_p(id), exp);
            chk1("held_valid", get_ov(id), 1'b1);
            chk1("held_in_ready", get_ir(id), 1'b0);
        end
        @(posedge clk); #1;
        set_or(id, 1'b0);
        @(negedge clk);
        chk1("post_handoff_ready", get_ir(id), 1'b1);
        chk1("post_handoff_valid", get_ov(id), 1'b0);
    endtask

    task automatic rand_run(int id, int count);
        logic [31:0] a, b, msb, ones;
        logic        s;
        msb  = 32'(1) << ((id == 0) ? 31 : 15);
        ones = (msb << 1) - 32'(1);
        for (int j = 0; j < count; j++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = msb;
                1: b = ones;
                2: a = 32'(0);
                3: begin a = msb; b = msb; end
                default: ;
            endcase
            accept(id, a, b, s);
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #1;
                set_or(id, 1'($urandom_range(0, 1)));
                @(negedge clk);
                if (get_ov(id) && get_or(id)) break;
            end
            chk1("rand_handoff", get_ov(id) && get_or(id), 1'b1);
            @(posedge clk); #1;
            set_or(id, 1'b0);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied, expected completion", nvec);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 32'h0, 32'h0, 1'b0, 1'b0);
        set_in(1, 32'h0, 32'h0, 1'b0, 1'b0);
        or0 = 1'b0;
        or1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            chk1("reset_in_ready", get_ir(id), 1'b1);
            chk1("reset_out_valid", get_ov(id), 1'b0);
            chk1("reset_busy", get_bz(id), 1'b0);
            chk("reset_product", get_p(id), 64'h0);
        end

        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0);
        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 0);
        run(0, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0);
        run(0, 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 0);
        run(0, 32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB, 0);
        run(0, 32'd3, 32'd5, 1'b0, 64'd15, 5);

        // Operands keep changing and in_valid stays high while the first job is in flight.
        accept(0, 32'd2, 32'd9, 1'b0);
        set_in(0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1);
        wait_ov(0, 60);
        chk("isolation_product", get_p(0), 64'h12);
        handoff(0);
        @(negedge clk);
        chk1("isolation_rearm_ready", get_ir(0), 1'b1);
        @(posedge clk); #1;
        set_in(0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
        wait_ov(0, 60);
        chk("isolation_second", get_p(0), 64'd2786347395);
        handoff(0);

        accept(0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("abort_out_valid", ov0, 1'b0);
        chk("abort_product", p0, 64'h0);
        chk1("abort_busy", bz0, 1'b0);
        chk1("abort_in_ready", ir0, 1'b1);
        repeat (40) @(negedge clk);
        chk1("abort_no_pulse", ov0, 1'b0);

        run(1, 32'h1234, 32'h5678, 1'b0, 64'h06260060, 0);
        run(1, 32'h8000, 32'h8000, 1'b1, 64'h40000000, 0);
        run(1, 32'hFFFF, 32'h0003, 1'b1, 64'hFFFFFFFD, 2);

        rand_run(0, 120);
        rand_run(1, 2000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
